// File: rtl/kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module   : kbd_matrix
// Brief    : PS/2 set-2 byte stream to ZX ROWSxCOLS key matrix, with
//            reference-counted positions shared between composite keys.
// Revision : 1.0
// ============================================================================
module kbd_matrix #(
  parameter int ROWS    = 8,
  parameter int COLS    = 5,
  parameter int CNT_W   = 2,
  parameter int TIMEOUT = 0
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic [7:0]  ps2data,
  input  logic        ps2hit,
  input  logic [15:0] A,
  output logic [7:0]  D,
  output logic        any_key
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  localparam logic [7:0] c_BYTE_BRK   = 8'hF0;
  localparam logic [7:0] c_BYTE_EXT   = 8'hE0;
  localparam logic [7:0] c_BYTE_PAUSE = 8'hE1;
  localparam logic [7:0] c_LALT_IDX   = 8'h11;
  localparam logic [2:0] c_PAUSE_SKIP = 3'd7;
  localparam logic [6:0] c_CS         = {1'b1, 3'd0, 3'd0};
  localparam logic [6:0] c_SS         = {1'b1, 3'd7, 3'd1};

  // Matrix target encoding: {valid, row[2:0], col[2:0]}
  function automatic logic [6:0] pos(input logic [2:0] row, input logic [2:0] col);
    return {1'b1, row, col};
  endfunction

  // Two targets per key index {ext, code[6:0]}; alt selects the symbol variant
  function automatic logic [13:0] key_map(input logic [7:0] idx, input logic alt);
    logic [6:0] t0;
    logic [6:0] t1;
    t0 = '0;
    t1 = '0;
    case (idx)
      8'h12: t0 = c_CS;
      8'h1A: t0 = pos(3'd0, 3'd1);
      8'h22: t0 = pos(3'd0, 3'd2);
      8'h21: t0 = pos(3'd0, 3'd3);
      8'h2A: t0 = pos(3'd0, 3'd4);
      8'h1C: t0 = pos(3'd1, 3'd0);
      8'h1B: t0 = pos(3'd1, 3'd1);
      8'h23: t0 = pos(3'd1, 3'd2);
      8'h2B: t0 = pos(3'd1, 3'd3);
      8'h34: t0 = pos(3'd1, 3'd4);
      8'h15: t0 = pos(3'd2, 3'd0);
      8'h1D: t0 = pos(3'd2, 3'd1);
      8'h24: t0 = pos(3'd2, 3'd2);
      8'h2D: t0 = pos(3'd2, 3'd3);
      8'h2C: t0 = pos(3'd2, 3'd4);
      8'h16: t0 = pos(3'd3, 3'd0);
      8'h1E: t0 = pos(3'd3, 3'd1);
      8'h26: t0 = pos(3'd3, 3'd2);
      8'h25: t0 = pos(3'd3, 3'd3);
      8'h2E: t0 = pos(3'd3, 3'd4);
      8'h45: t0 = pos(3'd4, 3'd0);
      8'h46: t0 = pos(3'd4, 3'd1);
      8'h3E: t0 = pos(3'd4, 3'd2);
      8'h3D: t0 = pos(3'd4, 3'd3);
      8'h36: t0 = pos(3'd4, 3'd4);
      8'h4D: t0 = pos(3'd5, 3'd0);
      8'h44: t0 = pos(3'd5, 3'd1);
      8'h43: t0 = pos(3'd5, 3'd2);
      8'h3C: t0 = pos(3'd5, 3'd3);
      8'h35: t0 = pos(3'd5, 3'd4);
      8'h5A: t0 = pos(3'd6, 3'd0);
      8'h4B: t0 = pos(3'd6, 3'd1);
      8'h42: t0 = pos(3'd6, 3'd2);
      8'h3B: t0 = pos(3'd6, 3'd3);
      8'h33: t0 = pos(3'd6, 3'd4);
      8'h29: t0 = pos(3'd7, 3'd0);
      8'h59: t0 = c_SS;
      8'h3A: t0 = pos(3'd7, 3'd2);
      8'h31: t0 = pos(3'd7, 3'd3);
      8'h32: t0 = pos(3'd7, 3'd4);
      8'h58: begin t0 = c_CS; t1 = c_SS;            end
      8'h0D: begin t0 = c_CS; t1 = pos(3'd3, 3'd0); end
      8'h66: begin t0 = c_CS; t1 = pos(3'd4, 3'd0); end
      8'h76: begin t0 = c_CS; t1 = pos(3'd7, 3'd0); end
      // Arrows: keypad (ext=0) and cursor block (ext=1)
      8'h75, 8'hF5: begin t0 = c_CS; t1 = pos(3'd4, 3'd3); end
      8'h6B, 8'hEB: begin t0 = c_CS; t1 = pos(3'd3, 3'd4); end
      8'h72, 8'hF2: begin t0 = c_CS; t1 = pos(3'd4, 3'd4); end
      8'h74, 8'hF4: begin t0 = c_CS; t1 = pos(3'd4, 3'd2); end
      8'h41: begin t0 = c_SS; t1 = alt ? pos(3'd2, 3'd3) : pos(3'd7, 3'd3); end
      8'h49: begin t0 = c_SS; t1 = alt ? pos(3'd2, 3'd4) : pos(3'd7, 3'd2); end
      8'h4A: begin t0 = c_SS; t1 = alt ? pos(3'd0, 3'd3) : pos(3'd0, 3'd4); end
      8'h4C: begin t0 = c_SS; t1 = alt ? pos(3'd0, 3'd1) : pos(3'd5, 3'd1); end
      8'h52: begin t0 = c_SS; t1 = alt ? pos(3'd5, 3'd0) : pos(3'd4, 3'd3); end
      8'h4E: begin t0 = c_SS; t1 = alt ? pos(3'd4, 3'd0) : pos(3'd6, 3'd3); end
      8'h55: begin t0 = c_SS; t1 = alt ? pos(3'd6, 3'd2) : pos(3'd6, 3'd1); end
      default: ;
    endcase
    return {t1, t0};
  endfunction

  // {valid, slot} of the alt latch owned by each symbol key
  function automatic logic [3:0] sym_slot(input logic [7:0] idx);
    logic [3:0] s;
    s = 4'b0000;
    case (idx)
      8'h41: s = 4'b1000;
      8'h49: s = 4'b1001;
      8'h4A: s = 4'b1010;
      8'h4C: s = 4'b1011;
      8'h52: s = 4'b1100;
      8'h4E: s = 4'b1101;
      8'h55: s = 4'b1110;
      default: ;
    endcase
    return s;
  endfunction

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_skip;
  logic [2:0]         w_skip_next;
  logic [255:0]       r_held;
  logic [6:0]         r_alt_latch;
  logic               r_lalt;
  logic               w_make;
  logic               w_break;
  logic               w_ext;
  logic               w_reset_code;
  logic               w_release_all;
  logic               w_wd_expire;
  logic [7:0]         w_idx;
  logic               w_code_ok;
  logic [3:0]         w_sym;
  logic               w_alt_sel;
  logic [13:0]        w_map;
  logic               w_mapped;
  logic               w_do_make;
  logic               w_do_break;
  logic               w_lalt_make;
  logic               w_lalt_break;
  logic [ROWS*COLS-1:0] w_nz;
  logic               w_unused_addr;

  assign w_unused_addr = ^A[7:0];

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    w_make       = 1'b0;
    w_break      = 1'b0;
    w_ext        = 1'b0;
    w_reset_code = 1'b0;
    if (ps2hit) begin
      case (r_state)
        S_IDLE: begin
          if (ps2data == c_BYTE_BRK) begin
            w_state_next = S_BRK;
          end else if (ps2data == c_BYTE_EXT) begin
            w_state_next = S_EXT;
          end else if (ps2data == c_BYTE_PAUSE) begin
            w_state_next = S_PAUSE;
            w_skip_next  = c_PAUSE_SKIP;
          end else begin
            w_make       = 1'b1;
            w_reset_code = (ps2data == 8'hAA) || (ps2data == 8'h00) || (ps2data == 8'hFF);
          end
        end
        S_EXT: begin
          if (ps2data == c_BYTE_BRK) begin
            w_state_next = S_EXT_BRK;
          end else begin
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_BRK: begin
          w_break      = 1'b1;
          w_state_next = S_IDLE;
        end
        S_EXT_BRK: begin
          w_break      = 1'b1;
          w_ext        = 1'b1;
          w_state_next = S_IDLE;
        end
        S_PAUSE: begin
          w_skip_next = r_skip - 3'd1;
          if (r_skip <= 3'd1) begin
            w_skip_next  = 3'd0;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
    // Release-all overrides whatever the byte would otherwise have done
    w_release_all = w_reset_code | w_wd_expire;
    if (w_release_all) begin
      w_state_next = S_IDLE;
      w_skip_next  = 3'd0;
      w_make       = 1'b0;
      w_break      = 1'b0;
    end
  end

  assign w_idx     = {w_ext, ps2data[6:0]};
  assign w_code_ok = ~ps2data[7];
  assign w_sym     = sym_slot(w_idx);
  // A break must hit the same symbol variant that its make chose
  assign w_alt_sel = w_make ? r_lalt : r_alt_latch[w_sym[2:0]];
  assign w_map     = key_map(w_idx, w_alt_sel);
  assign w_mapped  = w_map[13] | w_map[6];

  assign w_do_make    = w_make  & w_code_ok & w_mapped & ~r_held[w_idx];
  assign w_do_break   = w_break & w_code_ok & r_held[w_idx];
  assign w_lalt_make  = w_make  & w_code_ok & (w_idx == c_LALT_IDX);
  assign w_lalt_break = w_break & w_code_ok & (w_idx == c_LALT_IDX);

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_held      <= '0;
      r_alt_latch <= '0;
      r_lalt      <= 1'b0;
    end else if (w_release_all) begin
      r_held      <= '0;
      r_alt_latch <= '0;
      r_lalt      <= 1'b0;
    end else begin
      if (w_do_make) begin
        r_held[w_idx] <= 1'b1;
        if (w_sym[3]) begin
          r_alt_latch[w_sym[2:0]] <= r_lalt;
        end
      end
      if (w_do_break) begin
        r_held[w_idx] <= 1'b0;
      end
      if (w_lalt_make) begin
        r_lalt <= 1'b1;
      end else if (w_lalt_break) begin
        r_lalt <= 1'b0;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [CNT_W-1:0] r_cnt;
      logic             w_hit;

      assign w_hit = (w_map[6]  && (w_map[5:3]  == 3'(r)) && (w_map[2:0] == 3'(c))) ||
                     (w_map[13] && (w_map[12:10] == 3'(r)) && (w_map[9:7] == 3'(c)));

      always_ff @(posedge clock_50) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (w_release_all) begin
          r_cnt <= '0;
        end else if (w_do_make && w_hit) begin
          if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (w_do_break && w_hit) begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      end

      assign w_nz[r*COLS+c] = |r_cnt;
    end
  end

  assign any_key = |w_nz;

  always_comb begin
    D = 8'hFF;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_nz[r*COLS+c] && !A[8+r]) begin
          D[c] = 1'b0;
        end
      end
    end
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [c_WD_W-1:0] r_wd;

    assign w_wd_expire = any_key & ~ps2hit & (r_wd == c_WD_W'(TIMEOUT - 1));

    always_ff @(posedge clock_50) begin
      if (!reset_n) begin
        r_wd <= '0;
      end else if (ps2hit || !any_key || w_wd_expire) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + c_WD_W'(1);
      end
    end
  end else begin : g_no_wd
    assign w_wd_expire = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_matrix
// Brief    : Directed PS/2 byte sequences with a scoreboard of expected
//            port-FE reads, checked by an independent monitor.
// Revision : 1.0
// ============================================================================
module tb_kbd_matrix;

  logic        clock_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  ps2data  = 8'h00;
  logic        ps2hit   = 1'b0;
  logic [15:0] A        = 16'hFFFF;
  logic [7:0]  D;
  logic        any_key;

  typedef struct {
    logic [7:0] d;
    logic       any;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic chk = 1'b0;
  logic fin = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #10 clock_50 = ~clock_50;

  kbd_matrix #(
    .ROWS(8),
    .COLS(5),
    .CNT_W(2),
    .TIMEOUT(100)
  ) dut (
    .clock_50(clock_50),
    .reset_n (reset_n),
    .ps2data (ps2data),
    .ps2hit  (ps2hit),
    .A       (A),
    .D       (D),
    .any_key (any_key)
  );

  task automatic send(input logic [7:0] b);
    ps2data = b;
    ps2hit  = 1'b1;
    @(negedge clock_50);
    ps2hit  = 1'b0;
  endtask

  task automatic check(input logic [15:0] addr, input logic [7:0] exp_d,
                       input logic exp_any, input string name);
    A = addr;
    sb.push_back('{d: exp_d, any: exp_any, name: name});
    chk = 1'b1;
    @(negedge clock_50);
    chk = 1'b0;
  endtask

  always @(posedge clock_50) begin
    if (chk) begin
      #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: read with no expected entry");
      end else begin
        e = sb.pop_front();
        if (D !== e.d || any_key !== e.any) begin
          bad++;
          $display("FAIL %s: got D=%h any_key=%b, want D=%h any_key=%b",
                   e.name, D, any_key, e.d, e.any);
        end
      end
    end
    if (fin) begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Bytes offered during reset must be ignored
    ps2data = 8'h1A;
    ps2hit  = 1'b1;
    repeat (3) @(negedge clock_50);
    ps2hit  = 1'b0;
    reset_n = 1'b1;

    check(16'hFEFE, 8'hFF, 1'b0, "reset_row0");
    check(16'h0000, 8'hFF, 1'b0, "reset_all_rows");

    send(8'h1A);
    check(16'hFEFE, 8'hFD, 1'b1, "z_make");
    send(8'hF0); send(8'h1A);
    check(16'hFEFE, 8'hFF, 1'b0, "z_break");

    // Shared CAPS SHIFT between LShift and cursor up
    send(8'h12); send(8'hE0); send(8'h75);
    check(16'hFEFE, 8'hFE, 1'b1, "cs_shared");
    check(16'hEFFE, 8'hF7, 1'b1, "up_is_7");
    send(8'hE0); send(8'hF0); send(8'h75);
    check(16'hFEFE, 8'hFE, 1'b1, "cs_still_held");
    check(16'hEFFE, 8'hFF, 1'b1, "up_released");
    send(8'hF0); send(8'h12);
    check(16'hFEFE, 8'hFF, 1'b0, "cs_released");

    send(8'h1C); send(8'h1C); send(8'h1C);
    check(16'hFDFE, 8'hFE, 1'b1, "typematic_held");
    send(8'hF0); send(8'h1C);
    check(16'hFDFE, 8'hFF, 1'b0, "typematic_break");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check(16'h0000, 8'hFF, 1'b0, "pause_no_effect");
    send(8'h15);
    check(16'hFBFE, 8'hFE, 1'b1, "after_pause_q");
    send(8'hF0); send(8'h15);

    // Symbol variant chosen at make, kept through LAlt changes
    send(8'h11); send(8'h41);
    check(16'h7FFE, 8'hFD, 1'b1, "alt_sym_ss");
    check(16'hFBFE, 8'hF7, 1'b1, "alt_sym_r");
    send(8'hF0); send(8'h11); send(8'hF0); send(8'h41);
    check(16'h0000, 8'hFF, 1'b0, "alt_latched_break");
    send(8'h41);
    check(16'h7FFE, 8'hF5, 1'b1, "plain_sym_ss_n");
    send(8'h11); send(8'hF0); send(8'h41);
    check(16'h0000, 8'hFF, 1'b0, "plain_latched_break");
    send(8'hF0); send(8'h11);

    send(8'h58);
    check(16'h7EFE, 8'hFC, 1'b1, "caps_cs_ss");
    send(8'hF0); send(8'h58);
    check(16'h0000, 8'hFF, 1'b0, "caps_break");

    send(8'hE0); send(8'h12);
    check(16'h0000, 8'hFF, 1'b0, "fake_shift_ignored");
    send(8'h9A);
    check(16'h0000, 8'hFF, 1'b0, "high_code_ignored");

    // CAPS SHIFT counter saturates at 3, then floors at 0
    send(8'h12); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h72);
    check(16'hFEFE, 8'hFE, 1'b1, "cs_four_holders");
    send(8'hF0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check(16'hFEFE, 8'hFF, 1'b1, "cs_saturated");
    check(16'hEFFE, 8'hEF, 1'b1, "down_is_6");
    send(8'hE0); send(8'hF0); send(8'h72);
    check(16'h0000, 8'hFF, 1'b0, "cs_floor");

    send(8'hE0); send(8'hF0);
    reset_n = 1'b0;
    @(negedge clock_50);
    reset_n = 1'b1;
    send(8'h75);
    check(16'hFEFE, 8'hFE, 1'b1, "reset_mid_seq_cs");
    check(16'hEFFE, 8'hF7, 1'b1, "reset_mid_seq_7");
    send(8'hF0); send(8'h75);
    check(16'h0000, 8'hFF, 1'b0, "reset_mid_seq_break");

    send(8'h29);
    repeat (50) @(negedge clock_50);
    check(16'h7FFE, 8'hFE, 1'b1, "wd_not_yet");
    repeat (60) @(negedge clock_50);
    check(16'h7FFE, 8'hFF, 1'b0, "wd_expired");

    send(8'h29);
    check(16'h7FFE, 8'hFE, 1'b1, "space_held");
    send(8'hAA);
    check(16'h7FFE, 8'hFF, 1'b0, "aa_release_all");
    send(8'h1A);
    check(16'hFEFE, 8'hFD, 1'b1, "after_release_idle");
    send(8'hF0); send(8'h1A);

    send(8'h11); send(8'h00); send(8'h41);
    check(16'h7FFE, 8'hF5, 1'b1, "lalt_cleared");
    send(8'hF0); send(8'h41);
    check(16'h0000, 8'hFF, 1'b0, "final_idle");

    repeat (3) @(negedge clock_50);
    fin = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/kbd_matrix.md
# kbd_matrix

Parametrised successor to the ZX keyboard controller. It decodes the PS/2 set‑2 byte stream into a ROWS×COLS ZX key matrix using a prefix-aware state machine (E0/F0/E1). Per-position reference counts let composite keys (arrows, DEL, symbols) share CAPS/SYMBOL SHIFT without releasing each other. Typematic repeats, Pause sequences, controller overrun and lost break codes (watchdog) are handled. The block sits between the PS/2 receiver and the Z80 port‑FE read path.

## Interface
- ROWS, 8, matrix rows; row r is selected by A[8+r] low; 1..8
- COLS, 5, matrix columns; driven onto D[COLS-1:0]; 1..8
- CNT_W, 2, reference counter width per matrix position; saturating
- TIMEOUT, 0, clock_50 cycles of ps2hit inactivity before release-all while any key is held; 0 disables

- clock_50  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- ps2data  in  8  received PS/2 byte, valid when ps2hit=1
- ps2hit  in  1  one-cycle strobe per received byte
- A  in  16  CPU address; A[15:8] selects rows
- D  out  8  column data, active-low; bits ≥COLS read 1
- any_key  out  1  1 when any matrix counter is nonzero

## Operation
- Decoder FSM states:
  - IDLE: F0→BRK; E0→EXT; E1→PAUSE with skip=7; otherwise a make of {ext=0,code}.
  - EXT: F0→EXT_BRK; otherwise a make of {1,code}, then IDLE.
  - BRK: break of {0,code}, then IDLE.
  - EXT_BRK: break of {1,code}, then IDLE.
  - PAUSE: each byte decrements skip; at 0 go to IDLE; no matrix effect.
- Held vector: 256 bits indexed {ext,code[6:0]}; codes ≥0x80 are never mapped.
  - Make of an already-held index is a typematic repeat and is ignored.
  - Break of an index that is not held is ignored.
- Mapping: the standard ZX 40-key layout, rows 0..7 as in the existing controller (LShift=CS [0][0], RShift=SS [7][1], Enter, Space).
  - Composite (CS+key): CapsLock→CS+SS; Tab→CS+1; Backspace→CS+0; Esc→CS+Space.
  - Arrows, both E0 and keypad: up→CS+7, left→CS+5, down→CS+6, right→CS+8.
  - Symbols (SS+key) for , . / ; ' - =: second target selected by LAlt state (0x11).
  - The selected target is latched per symbol key at make; the break decrements the same target even if LAlt has changed since.
  - LAlt itself does not enter the matrix.
  - E0 12 (fake shift) and unmapped codes are ignored.
- Make of a mapped index: set held; increment each target counter (saturate at 2^CNT_W−1).
- Break of a held index: clear held; decrement each target counter (floor 0).
- A position reads pressed while its counter is nonzero.
- D[c] = AND over r<ROWS of (cnt[r][c]==0 | A[8+r]); D[7:COLS] = 1.
- Release-all clears all counters, held bits, alt latches and LAlt, and forces the FSM to IDLE. It is triggered by:
  - byte AA, 00 or FF received in IDLE;
  - watchdog expiry.
- Watchdog: counter reloads on every ps2hit; counts only while any_key=1; expires after TIMEOUT cycles without a hit.
- A byte arriving in an unexpected state (e.g. E0 in BRK) is processed as the current state dictates; no error state exists.

## Timing
- Reset (reset_n=0 at a clock edge): FSM IDLE, skip 0, all counters 0, held and latches clear, LAlt 0, watchdog 0.
  - Outputs after reset: D=8'hFF for any A; any_key=0.
- Reset mid-sequence (e.g. after E0 F0) discards the partial sequence.
- Latency: counters update on the clock edge that samples ps2hit=1. D and any_key are combinational from counters and A, so they are valid the next cycle.
- Back-to-back ps2hit on consecutive cycles must be accepted; one byte per cycle.
- Release-all and a simultaneous make/break in the same cycle: release-all wins.
- ps2hit ignored while reset_n=0.

## Test plan
- Reset, then A=16'hFEFE → D=8'hFF, any_key=0.
- Bytes 1A; read A=FEFE → D=8'hFD (Z pressed). Then bytes F0 1A → D=8'hFF.
- Shared shift: press LShift (12), then E0 75 (up); send E0 F0 75 → A=FEFE gives D bit0=0 (CS still held) and A=EFFE gives D=8'hFF. Then F0 12 → A=FEFE gives D=8'hFF.
- Typematic: 1C 1C 1C then F0 1C → A=FDFE reads D=8'hFF, counter 0.
- Pause: E1 14 77 E1 F0 14 F0 77 → no matrix change, FSM back in IDLE. A following 15 press reads D=8'hFE at A=FBFE.
- Watchdog with TIMEOUT=100: press 29 and stay silent for 100 cycles → at A=7FFE, D=8'hFF and any_key=0. Send AA with a key held → same release-all result.
